// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for the sync_fifo block.
package sync_fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_DEPTH      = 16;

   // Occupancy must represent 0..depth inclusive, hence one extra bit.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// fifo_mem: storage array for sync_fifo, one write port, one asynchronous read port, no reset.
module fifo_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is registered on pop.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned AF_LEVEL   = DEPTH - 2,
   parameter int unsigned AE_LEVEL   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          pop,
   input  logic                          clr_err,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = count_width(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] head;
   logic                  push_ok;
   logic                  pop_ok;

   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);

         if (push_ok && !pop_ok)      count <= count + CW'(1);
         else if (pop_ok && !push_ok) count <= count - CW'(1);

         // New error events win over a simultaneous clear.
         if (push && !push_ok) overflow <= 1'b1;
         else if (clr_err)     overflow <= 1'b0;

         if (pop && !pop_ok)   underflow <= 1'b1;
         else if (clr_err)     underflow <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : head;
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        data_out <= '0;
      else if (pop_ok) data_out <= head;
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table plus scoreboarded directed and random sequences.
module tb_sync_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 14;
   localparam int unsigned AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]    count;

   sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .clr_err      (clr_err),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   int unsigned   n_vec = 0;
   int unsigned   n_err = 0;
   logic [DW-1:0] q[$];
   logic          m_ov = 1'b0;
   logic          m_un = 1'b0;
   logic [DW-1:0] m_dout = '0;

   typedef struct {
      logic          p;
      logic          r;
      logic          c;
      logic [DW-1:0] d;
      int unsigned   cnt;
      logic          emp;
      logic          ae;
      logic          ov;
      logic          un;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      int unsigned n = q.size();
      chk("count", 32'(count), n);
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
      if (n != 0) chk("data_out_head", 32'(data_out), 32'(q[0]));
`else
      chk("data_out", 32'(data_out), 32'(m_dout));
`endif
   endtask

   // Drive one cycle, update the scoreboard with the expected acceptance, then check after the edge.
   task automatic step(input logic p, input logic r, input logic c, input logic [DW-1:0] d);
      int unsigned n;
      logic        pop_ok, push_ok;
      @(negedge clk);
      push = p; pop = r; clr_err = c; data_in = d;
      n = q.size();
      pop_ok  = r && (n != 0);
      push_ok = p && ((n != DEPTH) || pop_ok);
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
      if (p && !push_ok) m_ov = 1'b1;
      else if (c)        m_ov = 1'b0;
      if (r && !pop_ok)  m_un = 1'b1;
      else if (c)        m_un = 1'b0;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
      check_state();
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'hA2, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'hA3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hA4, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      #1;
      check_state();
      chk("reset_data_out", 32'(data_out), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int unsigned i = 0; i < 13; i++) begin
         step(tbl[i].p, tbl[i].r, tbl[i].c, tbl[i].d);
         chk("tbl_count", 32'(count), tbl[i].cnt);
         chk("tbl_empty", 32'(empty), 32'(tbl[i].emp));
         chk("tbl_almost_empty", 32'(almost_empty), 32'(tbl[i].ae));
         chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ov));
         chk("tbl_underflow", 32'(underflow), 32'(tbl[i].un));
      end

      // 11 words in, 11 out
      for (int unsigned i = 1; i <= 11; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
      for (int unsigned i = 1; i <= 11; i++) step(1'b0, 1'b1, 1'b0, '0);
      chk("seq11_empty", 32'(empty), 32'h1);

      // Overfill: 21 pushes, only 16 stored
      for (int unsigned i = 0; i < 21; i++) begin
         step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
         if (i == 15) chk("full_at_16", 32'(full), 32'h1);
      end
      chk("overflow_set", 32'(overflow), 32'h1);
      for (int unsigned i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, '0);

      // Overdrain: 16 pushes, 21 pops
      for (int unsigned i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
      for (int unsigned i = 0; i < 21; i++) step(1'b0, 1'b1, 1'b0, '0);
      chk("underflow_set", 32'(underflow), 32'h1);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("underflow_clr", 32'(underflow), 32'h0);

      // Simultaneous push+pop while full
      for (int unsigned i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h80 + i));
      for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, DW'(8'hC0 + i));
      chk("full_pp_count", 32'(count), 32'd16);
      chk("full_pp_overflow", 32'(overflow), 32'h0);
      for (int unsigned i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0);

      // Almost-flag thresholds on the way up
      for (int unsigned i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, DW'($urandom_range(255)));
         if (i == 2)  chk("ae_off_at_3", 32'(almost_empty), 32'h0);
         if (i == 12) chk("af_off_at_13", 32'(almost_full), 32'h0);
         if (i == 13) chk("af_on_at_14", 32'(almost_full), 32'h1);
      end
      for (int unsigned i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0);

      // Random mix
      for (int unsigned i = 0; i < 300; i++)
         step(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(15) == 0),
              DW'($urandom_range(255)));
      step(1'b0, 1'b0, 1'b1, '0);

      // Mid-stream asynchronous reset at count 8
      while (q.size() > 0) step(1'b0, 1'b1, 1'b0, '0);
      for (int unsigned i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h10 + i));
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_dout = '0;
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_empty", 32'(empty), 32'h1);
      chk("mid_rst_data_out", 32'(data_out), 32'h0);
      check_state();
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b0, 8'hAA);
      step(1'b0, 1'b1, 1'b0, '0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("post_rst_pop", 32'(data_out), 32'hAA);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
